// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial unsigned a - b, LSB first, one full-adder stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_x;
    logic               w_y;
    logic               w_s;
    logic               w_cout;

    // Subtraction as a + ~b + 1: the initial carry of 1 supplies the +1.
    assign w_x    = r_a[0];
    assign w_y    = ~r_b[0];
    assign w_s    = w_x ^ w_y ^ r_carry;
    assign w_cout = (w_x & w_y) | (w_x & r_carry) | (w_y & r_carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            borrow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= 1'b1;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= {w_s, r_res[WIDTH-1:1]};
                    r_carry <= w_cout;
                    if (r_cnt == LAST_CNT) begin
                        diff    <= {w_s, r_res[WIDTH-1:1]};
                        borrow  <= ~w_cout;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL provide parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have ports (clock and reset first):
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a subtraction; sampled on rising edge.
- a  input  WIDTH  minuend; sampled only on an accepted start.
- b  input  WIDTH  subtrahend; sampled only on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking a completed result.
- diff  output  WIDTH  result a - b modulo 2^WIDTH.
- borrow  output  1  high when a < b (unsigned).
REQ-003 SHALL implement one clock domain with reset asynchronous and active-low; no other clocks or resets.

Function
REQ-004 SHALL compute a - b bit-serially, LSB first, one bit per RUN cycle, through one full-adder stage: x = a bit, y = inverted b bit, carry register fed back as cin.
REQ-005 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-006 IDLE: when start=1, SHALL load a and b into internal shift registers, set carry=1, set bit counter=0 and go to RUN. Otherwise it SHALL stay in IDLE.
REQ-007 RUN: on each edge SHALL:
- form s = x^y^cin and cout = majority(x, y, cin);
- shift s into the internal result register from the MSB side;
- set carry=cout;
- increment the counter.
REQ-008 RUN: on the edge where counter = WIDTH-1, SHALL copy the completed result to diff, set borrow = NOT(final cout) and go to DONE.
REQ-009 DONE: SHALL last exactly one cycle. It SHALL go to RUN if start=1 (loading as in REQ-006), and to IDLE otherwise.
REQ-010 busy SHALL be 1 exactly while in RUN and 0 in IDLE and DONE.
REQ-011 done SHALL be 1 exactly while in DONE.
REQ-012 Latency: with start accepted at edge E0, done SHALL be high in the cycle following edge E0+WIDTH. That is WIDTH RUN cycles, then done.
REQ-013 start SHALL be ignored while busy=1. Changes on a or b during RUN SHALL NOT affect the result.
REQ-014 diff and borrow SHALL change only on the RUN-to-DONE edge. Between operations, and throughout a following operation, they SHALL hold the last result.
REQ-015 Back-to-back: start=1 during DONE SHALL begin a new operation with no idle cycle. The previous diff and borrow SHALL remain valid until the new operation completes.
REQ-016 Arithmetic SHALL be unsigned modulo 2^WIDTH; borrow SHALL equal 1 if and only if a < b.
REQ-017 The internal counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap during RUN.

Reset
REQ-018 While rst_n=0, asynchronously:
- state = IDLE;
- busy = 0, done = 0, diff = 0, borrow = 0;
- carry, counter and shift registers cleared.
REQ-019 Reset asserted mid-RUN SHALL abort the operation with no done pulse, and diff SHALL read 0.
REQ-020 After rst_n rises, the first rising edge SHALL be able to accept start.

Verification (WIDTH=8)
REQ-021 a=0x05, b=0x03, start pulsed one cycle -> busy high 8 cycles, then done for 1 cycle with diff=0x02, borrow=0.
REQ-022 a=0x03, b=0x05 -> diff=0xFE, borrow=1. Also a=0x00, b=0x00 -> diff=0x00, borrow=0. Also a=0xFF, b=0x00 -> diff=0xFF, borrow=0. Also a=0x00, b=0xFF -> diff=0x01, borrow=1.
REQ-023 Start 0x10-0x01, then assert start with a=0xAA, b=0x55 on the 3rd RUN cycle -> second start ignored, diff=0x0F, busy pattern unchanged.
REQ-024 Start 0x20-0x10, hold start=1 with a=0x01, b=0x02 during DONE -> first done gives diff=0x10. The next cycle busy=1 with no idle gap, and the second done gives diff=0xFF, borrow=1.
REQ-025 Drop rst_n for one cycle during the 4th RUN cycle -> busy, done, diff and borrow go to 0 immediately with no done pulse. A fresh 0x09-0x04 then gives diff=0x05.
REQ-026 Exhaustive sweep: all 65536 (a, b) pairs give diff = (a-b) mod 256 and borrow = (a<b), each in exactly 9 edges from the start sample.
